// File: rtl/trace_stream_core.sv
// trace_stream_core
// Per-event performance counters, trace entry packing, a first-word-fall-through
// entry FIFO drained over an AXI4-Stream master with programmable tlast framing,
// and a rising/falling edge detector for the GPIO control write strobe.

module trace_stream_core #(
    parameter int NUM_EVENTS    = 37,
    parameter int COUNTER_WIDTH = 7,
    parameter int PAYLOAD_WIDTH = 160,
    parameter int FIFO_DEPTH    = 16,
    localparam int DATA_WIDTH   = PAYLOAD_WIDTH + NUM_EVENTS * COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_EVENTS-1:0]    events,
    input  logic [PAYLOAD_WIDTH-1:0] payload,
    input  logic                     write_enable,
    input  logic                     tlast_in,
    input  logic [31:0]              tlast_interval,
    output logic                     M_AXIS_tvalid,
    input  logic                     M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]    M_AXIS_tdata,
    output logic                     M_AXIS_tlast,
    input  logic                     ctrl_we,
    output logic                     ctrl_we_pos_edge,
    output logic                     ctrl_we_neg_edge,
    output logic                     overflow
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = NUM_EVENTS * COUNTER_WIDTH;

    // Event counters, one per event input
    logic [COUNTER_WIDTH-1:0] r_cnt [NUM_EVENTS];
    logic [CNT_BITS-1:0]      w_cnt_flat;

    // Entry storage; pointers carry one extra bit to tell full from empty
    logic [DATA_WIDTH-1:0]    r_mem      [FIFO_DEPTH];
    logic                     r_mem_last [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]      r_wr_ptr;
    logic [ADDR_WIDTH:0]      r_rd_ptr;

    logic [31:0]              r_interval_cnt;
    logic                     r_overflow;
    logic                     r_prev;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_interval_hit;

    // Fullness is judged from the registered pointers only, so a pop in the same
    // cycle never makes room for a write that arrives while the FIFO is full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_push  = write_enable && !w_full;
    assign w_pop   = !w_empty && M_AXIS_tready;

    assign w_interval_hit = (tlast_interval != 32'd0) &&
                            (r_interval_cnt == tlast_interval - 32'd1);

    // Pack the registered counters: counter[0] in the highest counter bits
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_cnt_flat = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            w_cnt_flat[(NUM_EVENTS-1-i)*COUNTER_WIDTH +: COUNTER_WIDTH] = r_cnt[i];
        end
    end

    // Count events; a trace write restarts each counter from this cycle's event bit
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (write_enable) begin
                    r_cnt[i] <= COUNTER_WIDTH'(events[i]);
                end else begin
                    r_cnt[i] <= r_cnt[i] + COUNTER_WIDTH'(events[i]);
                end
            end
        end
    end

    // Store accepted entries and their tlast flag
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale words are never visible because the pointers are reset.
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]]      <= {payload, w_cnt_flat};
            r_mem_last[r_wr_ptr[ADDR_WIDTH-1:0]] <= tlast_in || w_interval_hit;
        end
    end

    // Advance write/read pointers on push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
        end
    end

    // Count accepted writes for periodic tlast; frozen while the interval is 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_interval_cnt <= '0;
        end else if (w_push && (tlast_interval != 32'd0)) begin
            r_interval_cnt <= w_interval_hit ? 32'd0 : r_interval_cnt + 32'd1;
        end
    end

    // Sticky flag for any write dropped because the FIFO was full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (write_enable && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Remember last cycle's control write level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= ctrl_we;
        end
    end

    assign M_AXIS_tvalid    = !w_empty;
    assign M_AXIS_tdata     = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign M_AXIS_tlast     = !w_empty && r_mem_last[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign overflow         = r_overflow;
    assign ctrl_we_pos_edge = ctrl_we & ~r_prev;
    assign ctrl_we_neg_edge = ~ctrl_we & r_prev;

endmodule

// File: tb/tb_trace_stream_core.sv
// Bench for trace_stream_core: a reference model predicts every entry when the
// write is driven; a monitor pops and compares entries as the stream emits them.

module tb_trace_stream_core;

    localparam int NE    = 37;
    localparam int CW    = 7;
    localparam int PW    = 160;
    localparam int DEPTH = 16;
    localparam int DW    = PW + NE * CW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] events;
    logic [PW-1:0] payload;
    logic          write_enable;
    logic          tlast_in;
    logic [31:0]   tlast_interval;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready;
    logic [DW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tlast;
    logic          ctrl_we;
    logic          ctrl_we_pos_edge;
    logic          ctrl_we_neg_edge;
    logic          overflow;

    int            errors   = 0;
    int            checks   = 0;
    int            n_popped = 0;
    logic          mon_en   = 1'b0;

    exp_t          sb [$];
    logic [CW-1:0] m_cnt [NE];
    logic [31:0]   m_int;
    logic          m_ovf;

    trace_stream_core dut (
        .clk              (clk),
        .rst              (rst),
        .events           (events),
        .payload          (payload),
        .write_enable     (write_enable),
        .tlast_in         (tlast_in),
        .tlast_interval   (tlast_interval),
        .M_AXIS_tvalid    (M_AXIS_tvalid),
        .M_AXIS_tready    (M_AXIS_tready),
        .M_AXIS_tdata     (M_AXIS_tdata),
        .M_AXIS_tlast     (M_AXIS_tlast),
        .ctrl_we          (ctrl_we),
        .ctrl_we_pos_edge (ctrl_we_pos_edge),
        .ctrl_we_neg_edge (ctrl_we_neg_edge),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Monitor: compare stream state and popped entries against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (M_AXIS_tvalid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL tvalid: got %b expected %b", M_AXIS_tvalid, sb.size() != 0);
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
            end
            if (M_AXIS_tvalid && M_AXIS_tready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_popped++;
                checks++;
                if (M_AXIS_tdata !== e.data) begin
                    errors++;
                    $display("FAIL tdata pop %0d: got %h expected %h", n_popped, M_AXIS_tdata, e.data);
                end
                checks++;
                if (M_AXIS_tlast !== e.last) begin
                    errors++;
                    $display("FAIL tlast pop %0d: got %b expected %b", n_popped, M_AXIS_tlast, e.last);
                end
            end
        end
    end

    // One clock cycle of stimulus; predicts the entry and updates the model
    task automatic step(input logic [NE-1:0] ev, input logic we, input logic [PW-1:0] pl,
                        input logic tl);
        exp_t e;
        logic full;
        logic acc;
        logic hit;
        events       = ev;
        write_enable = we;
        payload      = pl;
        tlast_in     = tl;
        full = (sb.size() == DEPTH);
        acc  = we && !full;
        hit  = 1'b0;
        if (acc && tlast_interval != 32'd0) hit = (m_int == tlast_interval - 32'd1);
        e.last = tl || hit;
        e.data = '0;
        e.data[DW-1 -: PW] = pl;
        for (int i = 0; i < NE; i++) e.data[(NE-1-i)*CW +: CW] = m_cnt[i];
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back(e);
            if (tlast_interval != 32'd0) m_int = hit ? 32'd0 : m_int + 32'd1;
        end
        if (we && full) m_ovf = 1'b1;
        for (int i = 0; i < NE; i++) begin
            m_cnt[i] = we ? CW'(ev[i]) : m_cnt[i] + CW'(ev[i]);
        end
        events       = '0;
        write_enable = 1'b0;
        tlast_in     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        mon_en        = 1'b0;
        rst           = 1'b1;
        M_AXIS_tready = 1'b0;
        events        = '0;
        write_enable  = 1'b0;
        tlast_in      = 1'b0;
        payload       = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < NE; i++) m_cnt[i] = '0;
        m_int  = '0;
        m_ovf  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_we        = 1'b0;
        tlast_interval = '0;
        do_reset();
        checks++;
        if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL reset tvalid: got %b expected 0", M_AXIS_tvalid); end
        checks++;
        if (M_AXIS_tlast !== 1'b0) begin errors++; $display("FAIL reset tlast: got %b expected 0", M_AXIS_tlast); end
        checks++;
        if (M_AXIS_tdata !== '0) begin errors++; $display("FAIL reset tdata: got %h expected 0", M_AXIS_tdata); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", overflow); end
        checks++;
        if ({ctrl_we_pos_edge, ctrl_we_neg_edge} !== 2'b00) begin
            errors++; $display("FAIL reset edges: got %b expected 00", {ctrl_we_pos_edge, ctrl_we_neg_edge});
        end
    endtask

    task automatic test_edges();
        logic [3:0] seq;
        logic [3:0] exp_pos;
        logic [3:0] exp_neg;
        seq     = 4'b0110;
        exp_pos = 4'b0010;
        exp_neg = 4'b1000;
        ctrl_we = 1'b1;
        do_reset();
        checks++;
        if (ctrl_we_pos_edge !== 1'b1) begin
            errors++; $display("FAIL first-cycle pos_edge: got %b expected 1", ctrl_we_pos_edge);
        end
        ctrl_we = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            ctrl_we = seq[k];
            #1;
            checks++;
            if (ctrl_we_pos_edge !== exp_pos[k]) begin
                errors++; $display("FAIL pos_edge step %0d: got %b expected %b", k, ctrl_we_pos_edge, exp_pos[k]);
            end
            checks++;
            if (ctrl_we_neg_edge !== exp_neg[k]) begin
                errors++; $display("FAIL neg_edge step %0d: got %b expected %b", k, ctrl_we_neg_edge, exp_neg[k]);
            end
            @(posedge clk);
            #1;
        end
        ctrl_we = 1'b0;
    endtask

    task automatic test_counters();
        logic [NE-1:0] ev;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ev = '0;
            ev[0] = 1'b1;
            ev[1] = (k < 3);
            step(ev, 1'b0, '0, 1'b0);
        end
        ev = '0;
        ev[0] = 1'b1;
        step(ev, 1'b1, 160'hABC, 1'b0);
        checks++;
        if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL capture latency tvalid: got %b expected 1", M_AXIS_tvalid); end
        checks++;
        if (M_AXIS_tdata !== {160'hABC, 7'd5, 7'd3, 245'd0}) begin
            errors++; $display("FAIL capture entry: got %h expected %h", M_AXIS_tdata, {160'hABC, 7'd5, 7'd3, 245'd0});
        end
        M_AXIS_tready = 1'b1;
        idle(1);
        M_AXIS_tready = 1'b0;
        step('0, 1'b1, 160'h1, 1'b0);
        checks++;
        if (M_AXIS_tdata[DW-PW-1 -: 2*CW] !== {7'd1, 7'd0}) begin
            errors++; $display("FAIL counter restart: got %h expected %h", M_AXIS_tdata[DW-PW-1 -: 2*CW], {7'd1, 7'd0});
        end
        M_AXIS_tready = 1'b1;
        idle(2);
    endtask

    task automatic test_wrap();
        logic [NE-1:0] ev;
        do_reset();
        ev = '0;
        ev[0] = 1'b1;
        for (int k = 0; k < 130; k++) step(ev, 1'b0, '0, 1'b0);
        step('0, 1'b1, 160'h77, 1'b0);
        checks++;
        if (M_AXIS_tdata[DW-PW-1 -: CW] !== 7'd2) begin
            errors++; $display("FAIL counter wrap: got %0d expected 2", M_AXIS_tdata[DW-PW-1 -: CW]);
        end
        M_AXIS_tready = 1'b1;
        idle(2);
    endtask

    task automatic test_interval();
        do_reset();
        tlast_interval = 32'd3;
        M_AXIS_tready  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step('0, 1'b1, PW'(k + 100), 1'b0);
            checks++;
            if (M_AXIS_tlast !== (k == 2 || k == 5)) begin
                errors++; $display("FAIL interval tlast entry %0d: got %b expected %b", k + 1, M_AXIS_tlast, (k == 2 || k == 5));
            end
        end
        tlast_interval = 32'd0;
        for (int k = 0; k < 5; k++) begin
            step('0, 1'b1, PW'(k + 200), (k == 1));
            checks++;
            if (M_AXIS_tlast !== (k == 1)) begin
                errors++; $display("FAIL tlast_in entry %0d: got %b expected %b", k + 1, M_AXIS_tlast, (k == 1));
            end
        end
        idle(2);
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        for (int k = 0; k < 17; k++) step('0, 1'b1, PW'(k), 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow set: got %b expected 1", overflow); end
        base = n_popped;
        M_AXIS_tready = 1'b1;
        idle(18);
        checks++;
        if (n_popped - base != 16) begin errors++; $display("FAIL drained count: got %0d expected 16", n_popped - base); end
        checks++;
        if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL empty after drain: got %b expected 0", M_AXIS_tvalid); end
    endtask

    task automatic test_hold();
        do_reset();
        step('0, 1'b1, 160'h11, 1'b1);
        step('0, 1'b1, 160'h22, 1'b0);
        step('0, 1'b1, 160'h33, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            checks++;
            if (M_AXIS_tdata[DW-1 -: PW] !== 160'h11 || M_AXIS_tlast !== 1'b1) begin
                errors++; $display("FAIL hold cycle %0d: got %h/%b expected 11/1", k, M_AXIS_tdata[DW-1 -: PW], M_AXIS_tlast);
            end
        end
        M_AXIS_tready = 1'b1;
        idle(1);
        M_AXIS_tready = 1'b0;
        idle(2);
        checks++;
        if (M_AXIS_tdata[DW-1 -: PW] !== 160'h22 || M_AXIS_tlast !== 1'b0) begin
            errors++; $display("FAIL single pop: got %h/%b expected 22/0", M_AXIS_tdata[DW-1 -: PW], M_AXIS_tlast);
        end
        M_AXIS_tready = 1'b1;
        idle(3);
    endtask

    task automatic test_back_to_back();
        do_reset();
        tlast_interval = 32'd1;
        M_AXIS_tready  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(NE'({$urandom, $urandom}), 1'b1, PW'({$urandom, $urandom, $urandom}), 1'b0);
            checks++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tlast !== 1'b1) begin
                errors++; $display("FAIL streaming entry %0d: got tvalid=%b tlast=%b expected 1/1", k, M_AXIS_tvalid, M_AXIS_tlast);
            end
        end
        tlast_interval = 32'd0;
        M_AXIS_tready  = 1'b0;
        idle(1);
        for (int k = 0; k < DEPTH; k++) step('0, 1'b1, PW'(k + 300), 1'b0);
        M_AXIS_tready = 1'b1;
        step('0, 1'b1, 160'hDEAD, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL full with pop drops write: got %b expected 1", overflow); end
        idle(18);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 17; k++) step('1, 1'b1, PW'(k + 500), 1'b0);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < NE; i++) m_cnt[i] = '0;
        m_int  = '0;
        m_ovf  = 1'b0;
        mon_en = 1'b1;
        checks++;
        if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL mid reset tvalid: got %b expected 0", M_AXIS_tvalid); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid reset overflow: got %b expected 0", overflow); end
        step('0, 1'b1, 160'h5, 1'b0);
        checks++;
        if (M_AXIS_tdata !== {160'h5, 259'd0}) begin
            errors++; $display("FAIL counters cleared by reset: got %h expected %h", M_AXIS_tdata, {160'h5, 259'd0});
        end
        M_AXIS_tready = 1'b1;
        idle(2);
    endtask

    initial begin
        rst            = 1'b1;
        events         = '0;
        payload        = '0;
        write_enable   = 1'b0;
        tlast_in       = 1'b0;
        tlast_interval = '0;
        M_AXIS_tready  = 1'b0;
        ctrl_we        = 1'b0;
        m_int          = '0;
        m_ovf          = 1'b0;
        for (int i = 0; i < NE; i++) m_cnt[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_edges();
        test_counters();
        test_wrap();
        test_interval();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
